sync_fifo: RTL and testbench



---
 rtl/dual_port_memory.sv | 52 +++++
 rtl/sync_fifo.sv | 114 +++++++++++
 tb/tb_sync_fifo.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/dual_port_memory.sv
// ---------------------------------------------------------------------------
// dual_port_memory
//   Simple dual-port RAM: one write port, one read port, each with its own
//   clock and clock enable. The read is registered: read_data updates one
//   cycle after a read_enable and holds its value until the next read.
//
// Ports
//   write_clock         write-port clock
//   write_clock_enable  gates every write-port action
//   write_enable        store write_data at write_address
//   write_address       write location
//   write_data          word to store
//   read_clock          read-port clock
//   read_clock_enable   gates every read-port action
//   read_enable         load read_data from read_address
//   read_address        read location
//   read_data           registered read word; holds while no read occurs
// ---------------------------------------------------------------------------
module dual_port_memory #(
  parameter  int WIDTH      = 8,
  parameter  int DEPTH      = 512,
  localparam int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  write_clock,
  input  logic                  write_clock_enable,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_address,
  input  logic [WIDTH-1:0]      write_data,
  input  logic                  read_clock,
  input  logic                  read_clock_enable,
  input  logic                  read_enable,
  input  logic [ADDR_WIDTH-1:0] read_address,
  output logic [WIDTH-1:0]      read_data
);

  // NOTE: the storage array has no reset; clearing it would forbid mapping
  // onto block RAM, and every entry is written before it is ever read.
  logic [WIDTH-1:0] memory [DEPTH];

  always_ff @(posedge write_clock) begin
    if (write_clock_enable && write_enable) begin
      memory[write_address] <= write_data;
    end
  end

  always_ff @(posedge read_clock) begin
    if (read_clock_enable && read_enable) begin
      read_data <= memory[read_address];
    end
  end

endmodule

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
//   Single-clock first-word-fall-through FIFO with valid/ready on both sides.
//   Words live in a dual_port_memory; the memory's registered read_data acts
//   as the output stage, so total capacity is DEPTH + 1 words.
//
// Ports
//   clock        sole clock, rising edge
//   reset        synchronous, active-high
//   flush        synchronous clear of all contents (same effect as reset)
//   in_valid     producer offers in_data
//   in_ready     FIFO accepts a word this cycle (registered state only)
//   in_data      write data
//   out_valid    out_data holds the oldest word
//   out_ready    consumer takes out_data this cycle
//   out_data     head word, straight from the memory read port
//   level        words held: mem_count + out_valid
//   almost_full  mem_count >= ALMOST_FULL_LEVEL
//   overflow     sticky: in_valid seen while in_ready was low
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH             = 8,
  parameter int DEPTH             = 512,
  parameter int ALMOST_FULL_LEVEL = DEPTH - 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_data,
  output logic [$clog2(DEPTH+2)-1:0]    level,
  output logic                          almost_full,
  output logic                          overflow
);

  localparam int PTR_WIDTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int COUNT_WIDTH = $clog2(DEPTH + 1);
  localparam int LEVEL_WIDTH = $clog2(DEPTH + 2);

  localparam logic [PTR_WIDTH-1:0]   LAST_ADDR  = PTR_WIDTH'(DEPTH - 1);
  localparam logic [COUNT_WIDTH-1:0] FULL_COUNT = COUNT_WIDTH'(DEPTH);

  logic [PTR_WIDTH-1:0]   write_pointer;
  logic [PTR_WIDTH-1:0]   read_pointer;
  logic [COUNT_WIDTH-1:0] mem_count;
  logic                   clear;
  logic                   push;
  logic                   pop;
  logic                   fetch;

  // Pointers wrap by explicit compare so DEPTH need not be a power of two.
  function automatic logic [PTR_WIDTH-1:0] advance(input logic [PTR_WIDTH-1:0] ptr);
    return (ptr == LAST_ADDR) ? '0 : ptr + PTR_WIDTH'(1);
  endfunction

  assign clear    = reset | flush;
  assign in_ready = (mem_count != FULL_COUNT);
  assign push     = in_valid & in_ready;
  assign pop      = out_valid & out_ready;
  // Refill the output stage whenever it is empty or being emptied this cycle.
  assign fetch    = (mem_count != '0) & (~out_valid | out_ready);

  assign level       = LEVEL_WIDTH'(mem_count) + LEVEL_WIDTH'(out_valid);
  assign almost_full = (int'(mem_count) >= ALMOST_FULL_LEVEL);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clock) begin
    if (clear) begin
      write_pointer <= '0;
      read_pointer  <= '0;
      mem_count     <= '0;
      out_valid     <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      if (push)  write_pointer <= advance(write_pointer);
      if (fetch) read_pointer  <= advance(read_pointer);

      case ({push, fetch})
        2'b10:   mem_count <= mem_count + COUNT_WIDTH'(1);
        2'b01:   mem_count <= mem_count - COUNT_WIDTH'(1);
        default: mem_count <= mem_count;
      endcase

      if (fetch)    out_valid <= 1'b1;
      else if (pop) out_valid <= 1'b0;

      if (in_valid && !in_ready) overflow <= 1'b1;
    end
  end

  // Memory accesses are suppressed on a clearing cycle so a discarded push
  // or pop leaves no trace.
  dual_port_memory #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_memory (
    .write_clock        (clock),
    .write_clock_enable (1'b1),
    .write_enable       (push & ~clear),
    .write_address      (write_pointer),
    .write_data         (in_data),
    .read_clock         (clock),
    .read_clock_enable  (1'b1),
    .read_enable        (fetch & ~clear),
    .read_address       (read_pointer),
    .read_data          (out_data)
  );

endmodule

// File: tb/tb_sync_fifo.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo
//   Three sync_fifo instances (DEPTH 512, 8 and 6) share one clock and reset.
//   Only the instance under test is driven; the others idle. A small
//   behavioural model of the FIFO supplies expected values every cycle, and
//   directed checks pin the hand-computed milestones.
// ---------------------------------------------------------------------------
module tb_sync_fifo;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset;
  logic       iv   [3];
  logic       rdy  [3];
  logic       fl   [3];
  logic [7:0] din  [3];
  logic       ov   [3];
  logic       ir   [3];
  logic       af   [3];
  logic       of   [3];
  logic [7:0] dout [3];
  logic [9:0] lvl  [3];

  logic [9:0] lvl512;
  logic [3:0] lvl8;
  logic [2:0] lvl6;

  assign lvl[0] = lvl512;
  assign lvl[1] = {6'd0, lvl8};
  assign lvl[2] = {7'd0, lvl6};

  sync_fifo #(.WIDTH(8), .DEPTH(512)) u_d512 (
    .clock(clock), .reset(reset), .flush(fl[0]),
    .in_valid(iv[0]), .in_ready(ir[0]), .in_data(din[0]),
    .out_valid(ov[0]), .out_ready(rdy[0]), .out_data(dout[0]),
    .level(lvl512), .almost_full(af[0]), .overflow(of[0])
  );

  sync_fifo #(.WIDTH(8), .DEPTH(8)) u_d8 (
    .clock(clock), .reset(reset), .flush(fl[1]),
    .in_valid(iv[1]), .in_ready(ir[1]), .in_data(din[1]),
    .out_valid(ov[1]), .out_ready(rdy[1]), .out_data(dout[1]),
    .level(lvl8), .almost_full(af[1]), .overflow(of[1])
  );

  sync_fifo #(.WIDTH(8), .DEPTH(6)) u_d6 (
    .clock(clock), .reset(reset), .flush(fl[2]),
    .in_valid(iv[2]), .in_ready(ir[2]), .in_data(din[2]),
    .out_valid(ov[2]), .out_ready(rdy[2]), .out_data(dout[2]),
    .level(lvl6), .almost_full(af[2]), .overflow(of[2])
  );

  int depth_tab [3] = '{512, 8, 6};

  int tests  = 0;
  int failed = 0;

  // Reference model of the instance under test.
  int         cur;
  int         m_count;
  bit         m_ov;
  bit         m_of;
  logic [7:0] m_q [$];

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  task automatic model_clear();
    m_count = 0;
    m_ov    = 1'b0;
    m_of    = 1'b0;
    m_q.delete();
  endtask

  // One clock cycle on instance `cur`: drive inputs, advance the model, then
  // compare every output against it just after the edge.
  task automatic cycle(input logic v, input logic [7:0] d, input logic r, input logic f);
    int dep;
    bit push;
    bit pop;
    bit fetch;
    dep = depth_tab[cur];
    for (int i = 0; i < 3; i++) begin
      iv[i]  = 1'b0;
      rdy[i] = 1'b0;
      fl[i]  = 1'b0;
      din[i] = 8'h00;
    end
    iv[cur]  = v;
    din[cur] = d;
    rdy[cur] = r;
    fl[cur]  = f;
    if (f) begin
      model_clear();
    end else begin
      push  = v && (m_count != dep);
      pop   = m_ov && r;
      fetch = (m_count != 0) && (!m_ov || r);
      if (v && !push) m_of = 1'b1;
      if (pop)  void'(m_q.pop_front());
      if (push) m_q.push_back(d);
      m_count = m_count + int'(push) - int'(fetch);
      if (fetch)    m_ov = 1'b1;
      else if (pop) m_ov = 1'b0;
    end
    @(posedge clock);
    #1;
    check($sformatf("d%0d.out_valid", dep),   32'(ov[cur]),  32'(m_ov));
    check($sformatf("d%0d.in_ready", dep),    32'(ir[cur]),  32'(m_count != dep));
    check($sformatf("d%0d.level", dep),       32'(lvl[cur]), 32'(m_q.size()));
    check($sformatf("d%0d.almost_full", dep), 32'(af[cur]),  32'(m_count >= dep - 4));
    check($sformatf("d%0d.overflow", dep),    32'(of[cur]),  32'(m_of));
    if (m_ov) check($sformatf("d%0d.out_data", dep), 32'(dout[cur]), 32'(m_q[0]));
  endtask

  initial begin
    int sent;
    bit v;
    bit r;

    // ---- reset ----
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0; rdy[i] = 1'b0; fl[i] = 1'b0; din[i] = 8'h00;
    end
    repeat (2) @(posedge clock);
    #1;
    for (int i = 0; i < 3; i++) begin
      check("reset.out_valid",   32'(ov[i]),  32'd0);
      check("reset.in_ready",    32'(ir[i]),  32'd1);
      check("reset.level",       32'(lvl[i]), 32'd0);
      check("reset.almost_full", 32'(af[i]),  32'd0);
      check("reset.overflow",    32'(of[i]),  32'd0);
    end
    reset = 1'b0;
    model_clear();

    // ---- single word latency and stall hold (DEPTH 512) ----
    cur = 0;
    cycle(1'b1, 8'hA5, 1'b0, 1'b0);
    check("t1.not_valid_after_push", 32'(ov[0]), 32'd0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    check("t1.valid_cycle2", 32'(ov[0]),   32'd1);
    check("t1.data",         32'(dout[0]), 32'hA5);
    check("t1.level",        32'(lvl[0]),  32'd1);
    repeat (3) cycle(1'b0, 8'h00, 1'b0, 1'b0);
    check("t1.data_held", 32'(dout[0]), 32'hA5);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("t1.drained", 32'(lvl[0]), 32'd0);

    // ---- streaming 1000 words (DEPTH 512) ----
    for (int i = 0; i < 1000; i++) begin
      cycle(1'b1, 8'(i), 1'b1, 1'b0);
      check("t2.level_le2", 32'(lvl[0] <= 10'd2), 32'd1);
    end
    repeat (3) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("t2.empty",    32'(lvl[0]), 32'd0);
    check("t2.overflow", 32'(of[0]),  32'd0);

    // ---- fill to capacity (DEPTH 8) ----
    cur = 1;
    for (int i = 0; i < 9; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    check("t3.level_full",    32'(lvl[1]), 32'd9);
    check("t3.in_ready_low",  32'(ir[1]),  32'd0);
    check("t3.almost_full",   32'(af[1]),  32'd1);
    check("t3.no_overflow",   32'(of[1]),  32'd0);
    check("t3.head",          32'(dout[1]), 32'h10);
    cycle(1'b1, 8'h77, 1'b0, 1'b0);
    check("t3.overflow_set",  32'(of[1]),  32'd1);
    check("t3.level_same",    32'(lvl[1]), 32'd9);

    // ---- full: same-cycle pop and refused push ----
    cycle(1'b1, 8'h99, 1'b1, 1'b0);
    check("t5.level_after_pop", 32'(lvl[1]),  32'd8);
    check("t5.in_ready_back",   32'(ir[1]),   32'd1);
    check("t5.next_head",       32'(dout[1]), 32'h11);

    // ---- flush with push/pop in the same cycle ----
    repeat (3) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("t6.five_queued", 32'(lvl[1]), 32'd5);
    cycle(1'b1, 8'hEE, 1'b1, 1'b1);
    check("t6.out_valid", 32'(ov[1]),  32'd0);
    check("t6.level",     32'(lvl[1]), 32'd0);
    check("t6.in_ready",  32'(ir[1]),  32'd1);
    check("t6.overflow",  32'(of[1]),  32'd0);
    check("t6.almost",    32'(af[1]),  32'd0);
    cycle(1'b1, 8'h3C, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    check("t6.first_after_flush", 32'(dout[1]), 32'h3C);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("t6.drained", 32'(lvl[1]), 32'd0);

    // ---- non-power-of-two depth with random stalls (DEPTH 6) ----
    cur  = 2;
    sent = 0;
    for (int c = 0; c < 400 && !(sent == 20 && m_q.size() == 0); c++) begin
      v = (sent < 20) && ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) != 0);
      if (v && m_count != 6) begin
        cycle(v, 8'(8'h40 + sent), r, 1'b0);
        sent++;
      end else begin
        cycle(v, 8'(8'h40 + sent), r, 1'b0);
      end
    end
    check("t4.all_sent",    32'(sent),   32'd20);
    check("t4.all_drained", 32'(lvl[2]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
